// File: rtl/dmux_xfer_arb_pkg.sv
// dmux_xfer_arb_pkg: state encoding, default sizes and index-width helper shared by the DMUX transfer arbiter
package dmux_xfer_arb_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_GRANT_W = idx_w(DEF_NUM_REQ);
endpackage

// File: rtl/dmux_rr_pick.sv
// dmux_rr_pick: combinational round-robin picker, first set request searching upward from i_ptr with wrap
module dmux_rr_pick
  import dmux_xfer_arb_pkg::*;
#(
  parameter int N = DEF_NUM_REQ,
  parameter int W = DEF_GRANT_W
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  logic [W-1:0] w_pos;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = W'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_pos]) begin
        o_any = 1'b1;
        o_idx = w_pos;
        o_gnt[w_pos] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dmux_xfer_arb.sv
// dmux_xfer_arb: round-robin arbiter sharing one DMUX synchronizer between requesters.
// Optional ack timeout abort is enabled by defining DMUX_XFER_ARB_TIMEOUT_EN.
module dmux_xfer_arb
  import dmux_xfer_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DATA_WIDTH     = 39,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int GW = idx_w(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [DATA_WIDTH-1:0]         dmux_data,
  output logic                          dmux_vld,
  input  logic                          dmux_ack,
  output logic                          busy,
  output logic [GW-1:0]                 grant_id,
  output logic                          err_timeout
);
  localparam int HW = idx_w(HOLD_CYCLES);
  if (NUM_REQ < 1 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("dmux_xfer_arb: parameters out of range");
  end
  state_t                r_state;
  logic [GW-1:0]         r_rr_ptr;
  logic [GW-1:0]         r_grant_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_vld;
  logic                  r_ack_seen;
  logic [HW-1:0]         r_hold_cnt;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [GW-1:0]         w_idx;
  logic                  w_any;
  logic                  w_ack;
  dmux_rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
    .i_req (req_vld),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );
  assign w_ack     = r_ack_seen || dmux_ack;
  assign req_rdy   = (r_state == IDLE) ? w_gnt : '0;
  assign dmux_data = r_data;
  assign dmux_vld  = r_vld;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != IDLE);
`ifdef DMUX_XFER_ARB_TIMEOUT_EN
  localparam int TW = idx_w(TIMEOUT_CYCLES);
  logic [TW-1:0] r_to_cnt;
  logic          r_err;
  assign err_timeout = r_err;
`else
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_data     <= '0;
      r_vld      <= 1'b0;
      r_ack_seen <= 1'b0;
      r_hold_cnt <= '0;
`ifdef DMUX_XFER_ARB_TIMEOUT_EN
      r_to_cnt   <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_vld <= 1'b0;
`ifdef DMUX_XFER_ARB_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        IDLE: if (w_any) begin
          r_data     <= req_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
          r_grant_id <= w_idx;
          r_rr_ptr   <= GW'((int'(w_idx) + 1) % NUM_REQ);
          r_vld      <= 1'b1;
          r_state    <= LAUNCH;
        end
        LAUNCH: begin
          r_hold_cnt <= HW'(HOLD_CYCLES - 1);
          r_ack_seen <= dmux_ack;
`ifdef DMUX_XFER_ARB_TIMEOUT_EN
          r_to_cnt   <= '0;
`endif
          r_state    <= HOLD;
        end
        HOLD: begin
          r_ack_seen <= w_ack;
          if (r_hold_cnt == '0 && w_ack) r_state <= IDLE;
          else if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - 1'b1;
`ifdef DMUX_XFER_ARB_TIMEOUT_EN
          // abort only while no ack has ever been seen; rr_ptr already moved past this requester
          if (!w_ack) begin
            if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              r_state <= IDLE;
              r_err   <= 1'b1;
            end else r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmux_xfer_arb.sv
// tb_dmux_xfer_arb: randomized and directed checks of dmux_xfer_arb against a transfer-level timing model
module tb_dmux_xfer_arb;
  localparam int N  = 4;
  localparam int DW = 39;
  localparam int HC = 4;
  localparam int TO = 64;
  logic              clk_i = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_vld = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_rdy;
  logic [DW-1:0]     dmux_data;
  logic              dmux_vld;
  logic              dmux_ack = 1'b0;
  logic              busy;
  logic [1:0]        grant_id;
  logic              err_timeout;
  always #5 clk_i = ~clk_i;
  dmux_xfer_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .HOLD_CYCLES(HC), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .req_vld     (req_vld),
    .req_data    (req_data),
    .req_rdy     (req_rdy),
    .dmux_data   (dmux_data),
    .dmux_vld    (dmux_vld),
    .dmux_ack    (dmux_ack),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );
  int n_tests = 0;
  int n_fail = 0;
  int c = 0;
  bit m_busy = 0;
  bit m_err = 0;
  int m_ptr = 0;
  int m_gid = 0;
  int m_launch = -100;
  int m_ack = -1;
  logic [DW-1:0] m_data = '0;
  int req_mode = 0;
  logic [N-1:0] mask = '0;
  int ack_d = -5;
  int ack_d2 = -5;
  bit ack_rand = 0;
  bit ack_hi = 0;
  logic [DW-1:0] words [N];
  int rdy_q[$];
  int vld_q[$];
  int fall_q[$];
  int gid_q[$];
  logic [DW-1:0] dat_q[$];
  int n_err = 0;
  bit prev_busy = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, c, got, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic clr_obs();
    rdy_q.delete();
    vld_q.delete();
    fall_q.delete();
    gid_q.delete();
    dat_q.delete();
    n_err = 0;
  endtask
  task automatic model_reset();
    m_busy = 0;
    m_err = 0;
    m_ptr = 0;
    m_gid = 0;
    m_data = '0;
    m_launch = -100;
    m_ack = -1;
    prev_busy = 0;
  endtask
  task automatic step();
    int g;
    logic [N-1:0] e_rdy;
    @(negedge clk_i);
    if (req_mode == 2) begin
      req_vld = N'($urandom);
      for (int i = 0; i < N; i++) words[i] = DW'({$urandom, $urandom});
    end else req_vld = mask;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = words[i];
    dmux_ack = ack_rand ? ($urandom_range(3) == 0) :
               ack_hi ? 1'b1 : (m_busy && (c == m_launch + ack_d || c == m_launch + ack_d2));
    #1;
    g = pick(req_vld, m_ptr);
    e_rdy = (!m_busy && g >= 0) ? N'(1 << g) : '0;
    chk("req_rdy", 64'(req_rdy), 64'(e_rdy));
    chk("dmux_vld", 64'(dmux_vld), 64'(m_busy && c == m_launch));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("dmux_data", 64'(dmux_data), 64'(m_data));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("err_timeout", 64'(err_timeout), 64'(m_err));
    if (req_rdy != '0) rdy_q.push_back(c);
    if (dmux_vld) begin
      vld_q.push_back(c);
      gid_q.push_back(int'(grant_id));
      dat_q.push_back(dmux_data);
    end
    if (prev_busy && !busy) fall_q.push_back(c);
    prev_busy = busy;
    if (err_timeout) n_err++;
    m_err = 0;
    if (!m_busy) begin
      if (g >= 0) begin
        m_data = words[g];
        m_gid = g;
        m_ptr = (g + 1) % N;
        m_launch = c + 1;
        m_ack = -1;
        m_busy = 1;
        if (req_mode == 0) mask[g] = 1'b0;
      end
    end else begin
      if (dmux_ack && m_ack < 0) m_ack = c;
      if (c >= m_launch + HC && m_ack >= 0) m_busy = 0;
`ifdef DMUX_XFER_ARB_TIMEOUT_EN
      else if (m_ack < 0 && c == m_launch + TO) begin
        m_busy = 0;
        m_err = 1;
      end
`endif
    end
    c++;
  endtask
  task automatic do_reset();
    #2;
    reset = 1'b1;
    req_vld = '0;
    dmux_ack = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_vld", 64'(dmux_vld), 64'(0));
    chk("rst_data", 64'(dmux_data), 64'(0));
    chk("rst_gid", 64'(grant_id), 64'(0));
    chk("rst_err", 64'(err_timeout), 64'(0));
    chk("rst_rdy", 64'(req_rdy), 64'(0));
    model_reset();
    @(negedge clk_i);
    reset = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < N; i++) words[i] = DW'(64'h1_0000_0011 * (i + 3));
    words[1] = 39'h3456;
    repeat (2) @(negedge clk_i);
    do_reset();
    // single request with ack two cycles after the pulse
    req_mode = 0; mask = 4'b0010; ack_d = 2; ack_d2 = -5;
    clr_obs();
    repeat (10) step();
    chk("single_grants", 64'(rdy_q.size()), 64'(1));
    chk("single_gid", 64'(gid_q[0]), 64'(1));
    chk("single_data", 64'(dat_q[0]), 64'(39'h3456));
    chk("single_lat", 64'(fall_q[0] - rdy_q[0]), 64'(6));
    do_reset();
    // all requesters held high: strict rotation, one pulse per grant
    req_mode = 1; mask = 4'b1111; ack_d = 2;
    clr_obs();
    for (int k = 0; k < 60 && vld_q.size() < 5; k++) step();
    for (int k = 0; k < 5; k++) chk("rotation", 64'(gid_q[k]), 64'(k % 4));
    for (int k = 1; k < vld_q.size(); k++) chk("pulse_gap", 64'(vld_q[k] - vld_q[k-1] >= 6), 64'(1));
    chk("one_vld_per_grant", 64'(vld_q.size()), 64'(rdy_q.size()));
    req_mode = 0; mask = '0;
    repeat (8) step();
    // late ack ten cycles after the pulse
    mask = 4'b1001; ack_d = 10;
    clr_obs();
    for (int k = 0; k < 40 && rdy_q.size() < 2; k++) step();
    chk("late_lat", 64'(fall_q[0] - rdy_q[0]), 64'(12));
    chk("late_next_grant", 64'(rdy_q[1]), 64'(fall_q[0]));
    repeat (15) step();
    // ack in the launch cycle plus a second ack during hold
    mask = 4'b0010; ack_d = 0; ack_d2 = 2;
    clr_obs();
    repeat (10) step();
    chk("early_lat", 64'(fall_q[0] - rdy_q[0]), 64'(6));
    chk("early_grants", 64'(rdy_q.size()), 64'(1));
    // reset while in HOLD, then a pending request for requester 2
    mask = 4'b0010; ack_d = -5; ack_d2 = -5;
    clr_obs();
    repeat (4) step();
    chk("pre_rst_busy", 64'(busy), 64'(1));
    do_reset();
    mask = 4'b0100;
    clr_obs();
    repeat (4) step();
    chk("post_rst_gid", 64'(gid_q[0]), 64'(2));
    // random requests, data and acks
    req_mode = 2; ack_rand = 1;
    repeat (400) step();
    req_mode = 0; mask = '0; ack_rand = 0; ack_hi = 1;
    repeat (10) step();
    ack_hi = 0;
    // no ack at all
    req_mode = 1; mask = 4'b1111; ack_d = -5; ack_d2 = -5;
    clr_obs();
    repeat (80) step();
`ifdef DMUX_XFER_ARB_TIMEOUT_EN
    chk("timeout_pulses", 64'(n_err), 64'(1));
    chk("timeout_regrant", 64'(rdy_q.size()), 64'(2));
`else
    chk("noack_busy", 64'(busy), 64'(1));
    chk("noack_grants", 64'(rdy_q.size()), 64'(1));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmux_xfer_arb.md
Name: dmux_xfer_arb

Overview:
- Single-clock, round-robin arbiter that shares one DMUX clock-domain-crossing synchronizer between NUM_REQ source-domain requesters.
- Captures the granted word and holds it stable on the DMUX data input.
- Issues a one-cycle data_in_vld pulse to the DMUX.
- Holds off the next transfer until the destination acknowledge returns and a minimum hold time has elapsed.
- Sits in the clk_i (source) domain, directly in front of the DMUX instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 39, word width, matches DMUX DATA_WIDTH
- HOLD_CYCLES, 4, minimum cycles dmux_data stays stable after the launch cycle (>=1)
- TIMEOUT_CYCLES, 64, cycles in HOLD without ack before abort (used only with the optional feature)

Ports:
- clk_i  in  1  source-domain clock
- reset  in  1  asynchronous, active-high reset
- req_vld  in  NUM_REQ  per-requester transfer request, level
- req_data  in  NUM_REQ*DATA_WIDTH  packed words; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_rdy  out  NUM_REQ  one-hot accept strobe, combinational
- dmux_data  out  DATA_WIDTH  to DMUX data_in, registered
- dmux_vld  out  1  to DMUX data_in_vld, one-cycle pulse, registered
- dmux_ack  in  1  destination acknowledge pulse, already synchronized into clk_i
- busy  out  1  high when state != IDLE
- grant_id  out  $clog2(NUM_REQ)  index of last granted requester, registered
- err_timeout  out  1  one-cycle abort pulse

Behaviour:
- Reset (async, active-high): state=IDLE, rr_ptr=0, dmux_data=0, dmux_vld=0, grant_id=0, busy=0, err_timeout=0, ack_seen=0, hold_cnt=0. Reset mid-transfer aborts immediately; the in-flight word is dropped with no pulse.
- FSM states: IDLE -> LAUNCH -> HOLD -> IDLE.
- IDLE:
  - If any req_vld, select the first set bit searching from rr_ptr upward with wrap.
  - req_rdy[g]=1 in this cycle only; the requester drops or advances req_vld on the next edge.
  - On the edge: dmux_data<=req_data[g], grant_id<=g, rr_ptr<=(g+1) mod NUM_REQ, go to LAUNCH.
  - req_rdy is 0 in every other state and whenever no request is set.
- LAUNCH:
  - dmux_vld=1 for exactly this cycle.
  - hold_cnt<=HOLD_CYCLES-1, ack_seen<=0 (or 1 if dmux_ack is high this cycle), go to HOLD.
- HOLD:
  - ack_seen sets on dmux_ack.
  - If hold_cnt==0 and (ack_seen or dmux_ack), go to IDLE; otherwise hold_cnt decrements, saturating at 0.
- Latency: req_rdy at cycle t, dmux_vld at t+1, earliest IDLE at t+2+HOLD_CYCLES, earliest next req_rdy in that same cycle. dmux_data is constant from t+1 until the next grant.
- Boundaries:
  - dmux_ack in IDLE is ignored.
  - Multiple acks in one transfer count once.
  - Ack arriving before hold expiry is latched; exit still waits for hold_cnt==0.
  - All requesters continuously asserted: strict rotation 0,1,2,3,0,...
  - A requester that deasserts before grant is skipped.
  - With NUM_REQ=1, rr_ptr stays 0.

Optional Feature:
- Macro: DMUX_XFER_ARB_TIMEOUT_EN.
- Enabled:
  - A timeout counter clears on entry to HOLD and counts each HOLD cycle without an ack seen.
  - When it reaches TIMEOUT_CYCLES-1 with no ack, go to IDLE and pulse err_timeout for one cycle.
  - rr_ptr is already advanced, so no requester starves.
- Disabled: no counter logic; err_timeout is tied 0; HOLD waits for an ack indefinitely.

Decomposition:
- Package dmux_xfer_arb_pkg:
  - state enum typedef {IDLE, LAUNCH, HOLD}
  - localparam for grant index width
- One sub-module: dmux_rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr. Outputs: one-hot grant, grant index, any.

Test Plan:
- Reset then single request: req_vld=4'b0010, req_data[1]=39'h3456. Expect:
  - req_rdy=4'b0010 for one cycle
  - dmux_vld pulse at the next cycle with dmux_data=39'h3456, grant_id=1
  - ack 2 cycles after the pulse: busy falls 6 cycles after req_rdy (HOLD_CYCLES=4)
- All four requesters held high: grants in order 0,1,2,3,0; exactly one dmux_vld per grant; no two pulses closer than 6 cycles.
- Late ack, 10 cycles after the pulse: dmux_data stays stable throughout; IDLE is reached the cycle after the ack; the next grant follows immediately.
- Early ack, in the LAUNCH cycle: latched; exit still occurs exactly HOLD_CYCLES cycles after LAUNCH; a second ack during HOLD has no effect.
- Reset asserted in HOLD: all outputs return to reset values asynchronously; after release, the pending req_vld=4'b0100 is granted with rr_ptr=0 search (grant 2).
- With DMUX_XFER_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, no ack: err_timeout pulses once, busy drops, and the next requester is granted. Without the macro, busy stays high indefinitely.
